regex_scan_ctrl: RTL and testbench
==================================

REGEX_SCAN_CTRL -- requirements
Module: regex_scan_ctrl

Interface
REQ-001 Parameter POS_W, default 16, width of the character position and match counters.
REQ-002 Parameter MATCH_LAT, default 1, cycles from a character on m_char to its m_match result.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_start  in  1  one-cycle pulse that starts a frame scan; ignored unless in IDLE or DONE.
REQ-006 cmd_anchored  in  1  sampled with cmd_start; 1 means a start token on the first character only, 0 means a start token on every character.
REQ-007 in_valid / in_ready  in / out  1 / 1  character-stream handshake; a transfer occurs when both are high.
REQ-008 in_bit  in  1  character value (0 or 1).
REQ-009 in_last  in  1  marks the final character of the frame.
REQ-010 m_flush  out  1  clears the matcher token registers.
REQ-011 m_start  out  1  start token to the matcher.
REQ-012 m_char  out  1  character to the matcher.
REQ-013 m_match  in  1  matcher accept output.
REQ-014 hit  out  1  one-cycle pulse for each reported match.
REQ-015 hit_pos  out  POS_W  0-based index of the character that completed the match; valid with hit.
REQ-016 hit_count  out  POS_W  number of matches reported in the current frame.
REQ-017 busy / done  out  1 / 1  busy is high from FLUSH through DRAIN; done is high while in DONE.
REQ-018 ovf  out  1  sticky flag; the position counter saturated during this frame.

Function
REQ-019 The FSM SHALL have the states IDLE, FLUSH, SCAN, DRAIN and DONE.
REQ-020 IDLE/DONE + cmd_start -> FLUSH: m_flush=1 for exactly one cycle; clear pos, hit_count and ovf; latch cmd_anchored.
REQ-021 FLUSH -> SCAN unconditionally; in_ready=1 only in SCAN.
REQ-022 On each SCAN transfer: m_char=in_bit; m_start=1 if non-anchored, or if anchored and pos==0; pos increments.
- m_char and m_start are combinational from in_bit and state.
- Both are 0 when no transfer occurs.
REQ-023 The controller SHALL attribute m_match to the character transferred MATCH_LAT cycles earlier.
- A MATCH_LAT-deep pipeline carries {valid, pos} for this.
- m_match with no valid pipeline entry is ignored.
REQ-024 For an attributed match: hit=1, hit_pos=pipelined pos, hit_count+=1 (saturating at all-ones).
REQ-025 A transfer with in_last -> DRAIN.
- DRAIN lasts exactly MATCH_LAT cycles so the final character's match is caught.
- DRAIN -> DONE.
REQ-026 In DONE, done=1 and the frame's hit_count is held until the next cmd_start.
REQ-027 pos SHALL saturate at 2^POS_W-1; further characters set ovf=1 and report hit_pos=2^POS_W-1.
REQ-028 cmd_start while in FLUSH, SCAN or DRAIN SHALL be ignored.
REQ-029 in_valid outside SCAN SHALL transfer nothing and leave all state unchanged.
REQ-030 If a hit and in_last occur in the same cycle, both SHALL take effect.

Reset
REQ-031 reset SHALL be synchronous and active-high and SHALL take priority over all other inputs, including mid-frame.
REQ-032 Values while reset is high: state=IDLE; in_ready=0, m_start=0, m_char=0, hit=0, hit_pos=0, hit_count=0, busy=0, done=0, ovf=0; m_flush=1.
REQ-033 After reset, m_flush SHALL follow REQ-020.

Configuration
REQ-034 Macro REGEX_SCAN_STOP_ON_MATCH_EN selects first-hit mode.
- Defined: after the first hit of a frame, m_start and m_char are forced to 0 and later m_match is ignored.
- Defined: in_ready stays 1 until in_last; hit_count is at most 1.
- Undefined: every match is reported.

Structure
REQ-035 A shared package regex_pkg SHALL hold the FSM state enum and the POS_W default constant.
REQ-036 Sub-module regex_hit_pipe SHALL implement the MATCH_LAT delay line of {valid, pos}.
REQ-037 The matcher SHALL be external; the controller connects to its clk, reset (driven by m_flush), start-token, character and match ports.

Verification
Bench matcher model: m_match asserts 1 cycle after "1" follows "0" (MATCH_LAT=1).
REQ-038 Scenario: non-anchored, frame 0,1,0,1,1 with last on index 4 -> hits at pos 1 and 3; hit_count=2; done after 1 DRAIN cycle.
REQ-039 Scenario: anchored, same frame -> m_start high only on the index-0 transfer.
REQ-040 Scenario: reset asserted mid-frame at pos 2 -> next cycle IDLE and all outputs at REQ-032 values; a new cmd_start gives a fresh count starting at 0.
REQ-041 Scenario: POS_W=3, 10-character frame -> pos holds at 7 and ovf=1.
REQ-042 Scenario: in_valid toggling 1,0,1 plus a cmd_start pulse mid-SCAN -> only valid cycles advance pos; cmd_start has no effect.
REQ-043 Scenario: REGEX_SCAN_STOP_ON_MATCH_EN defined, frame 0,1,0,1 -> single hit at pos 1, hit_count=1, all 4 characters accepted.

Source files
------------

// File: rtl/regex_pkg.sv
// Shared types and defaults for the regex scan controller.
package regex_pkg;

  // Default width of the character position and match counters
  localparam int POS_W_DEFAULT = 16;

  // Default matcher latency from character to accept output
  localparam int MATCH_LAT_DEFAULT = 1;

  // Frame scan controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    SCAN  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } scan_state_t;

endpackage

// File: rtl/regex_hit_pipe.sv
// Delay line that carries {valid, pos} of each transferred character so a
// matcher accept arriving DEPTH cycles later can be tied back to its position.
module regex_hit_pipe #(
  parameter int DEPTH = 1,
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [POS_W-1:0] in_pos,
  output logic             out_valid,
  output logic [POS_W-1:0] out_pos
);

  logic [DEPTH-1:0] valid_q;
  logic [POS_W-1:0] pos_q [DEPTH];

  // Valid bits shift every cycle; reset and frame flush empty the line
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Positions shift alongside; they are only consumed when qualified by valid
  always_ff @(posedge clk) begin
    pos_q[0] <= in_pos;
    for (int i = 1; i < DEPTH; i++) begin
      pos_q[i] <= pos_q[i-1];
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_pos   = pos_q[DEPTH-1];

endmodule

// File: rtl/regex_scan_ctrl.sv
// Frame scan controller for an external token-passing regex matcher.
// Streams one character per handshake into the matcher, attributes each
// matcher accept back to the character position that completed it, and
// counts hits per frame.
// Optional build macro REGEX_SCAN_STOP_ON_MATCH_EN: stop feeding the matcher
// and ignore further accepts after the first hit of a frame.
module regex_scan_ctrl
  import regex_pkg::*;
#(
  parameter int POS_W     = POS_W_DEFAULT,
  parameter int MATCH_LAT = MATCH_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_start,
  input  logic             cmd_anchored,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             m_flush,
  output logic             m_start,
  output logic             m_char,
  input  logic             m_match,
  output logic             hit,
  output logic [POS_W-1:0] hit_pos,
  output logic [POS_W-1:0] hit_count,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int DRAIN_W = (MATCH_LAT > 1) ? $clog2(MATCH_LAT) : 1;
  localparam logic [POS_W-1:0]   POS_MAX    = '1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MATCH_LAT - 1);

  scan_state_t        state;
  scan_state_t        state_next;
  logic [POS_W-1:0]   pos;
  logic [POS_W-1:0]   hit_cnt_q;
  logic               anchored_q;
  logic               ovf_q;
  logic [DRAIN_W-1:0] drain_cnt;

  logic               frame_start;
  logic               xfer;
  logic               start_tok;
  logic               match_gate;
  logic               hit_int;
  logic               pipe_valid;
  logic [POS_W-1:0]   pipe_pos;

  // A new frame may only begin from an idle or finished controller
  assign frame_start = cmd_start && ((state == IDLE) || (state == DONE));

  // Characters are only accepted while scanning; reset blocks everything
  assign in_ready  = !reset && (state == SCAN);
  assign xfer      = in_ready && in_valid;

  // Anchored frames inject a start token only ahead of the first character
  assign start_tok = !anchored_q || (pos == '0);

`ifdef REGEX_SCAN_STOP_ON_MATCH_EN
  logic stopped_q;

  // Remember the first hit of the frame so the matcher is starved afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      stopped_q <= 1'b0;
    end else if (frame_start) begin
      stopped_q <= 1'b0;
    end else if (hit_int) begin
      stopped_q <= 1'b1;
    end
  end

  assign match_gate = !stopped_q;
`else
  assign match_gate = 1'b1;
`endif

  assign m_char  = xfer && match_gate && in_bit;
  assign m_start = xfer && match_gate && start_tok;

  // The matcher's register reset doubles as its per-frame flush
  assign m_flush = reset || (state == FLUSH);

  regex_hit_pipe #(
    .DEPTH (MATCH_LAT),
    .POS_W (POS_W)
  ) u_hit_pipe (
    .clk       (clk),
    .reset     (reset),
    .clear     (state == FLUSH),
    .in_valid  (xfer && match_gate),
    .in_pos    (pos),
    .out_valid (pipe_valid),
    .out_pos   (pipe_pos)
  );

  // An accept counts only when it lines up with a character that was fed in
  assign hit_int   = !reset && m_match && pipe_valid && match_gate;
  assign hit       = hit_int;
  assign hit_pos   = hit_int ? pipe_pos : '0;
  assign hit_count = reset ? '0 : hit_cnt_q;
  assign ovf       = !reset && ovf_q;
  assign busy      = !reset && ((state == FLUSH) || (state == SCAN) || (state == DRAIN));
  assign done      = !reset && (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: flush one cycle, scan to the last character, then wait
  // out the matcher latency so the final character's accept is not lost
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (cmd_start) state_next = FLUSH;
      FLUSH:   state_next = SCAN;
      SCAN:    if (xfer && in_last) state_next = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_next = DONE;
      DONE:    if (cmd_start) state_next = FLUSH;
      default: state_next = IDLE;
    endcase
  end

  // Frame bookkeeping: position, hit count, overflow flag and anchor mode
  always_ff @(posedge clk) begin
    if (reset) begin
      pos        <= '0;
      hit_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      anchored_q <= 1'b0;
    end else begin
      if (frame_start) begin
        pos        <= '0;
        hit_cnt_q  <= '0;
        ovf_q      <= 1'b0;
        anchored_q <= cmd_anchored;
      end
      if (xfer) begin
        if (pos == POS_MAX) begin
          ovf_q <= 1'b1;
        end else begin
          pos <= pos + POS_W'(1);
        end
      end
      if (hit_int && (hit_cnt_q != POS_MAX)) begin
        hit_cnt_q <= hit_cnt_q + POS_W'(1);
      end
    end
  end

  // Count drain cycles; the counter rests at zero outside DRAIN
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_cnt <= '0;
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt + DRAIN_W'(1);
    end else begin
      drain_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_regex_scan_ctrl.sv
// Directed bench for regex_scan_ctrl with a behavioural "01" token matcher.
// Two instances share stimulus: POS_W=16 and POS_W=3 (overflow checks).
module tb_regex_scan_ctrl;

`ifdef REGEX_SCAN_STOP_ON_MATCH_EN
  localparam logic STOP_MODE = 1'b1;
`else
  localparam logic STOP_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, cmd_start, cmd_anchored, in_valid, in_bit, in_last;

  logic        in_ready, m_flush, m_start, m_char, m_match, hit, busy, done, ovf;
  logic [15:0] hit_pos, hit_count;
  logic        in_ready_s, m_flush_s, m_start_s, m_char_s, m_match_s, hit_s, busy_s, done_s, ovf_s;
  logic [2:0]  hit_pos_s, hit_count_s;
  logic        tok, tok_s;

  int   checks = 0;
  int   errors = 0;
  logic seen_hit = 1'b0;

  always #5 clk = ~clk;

  regex_scan_ctrl #(.POS_W(16), .MATCH_LAT(1)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_anchored(cmd_anchored),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
    .m_flush(m_flush), .m_start(m_start), .m_char(m_char), .m_match(m_match),
    .hit(hit), .hit_pos(hit_pos), .hit_count(hit_count),
    .busy(busy), .done(done), .ovf(ovf)
  );

  regex_scan_ctrl #(.POS_W(3), .MATCH_LAT(1)) dut_s (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_anchored(cmd_anchored),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_bit(in_bit), .in_last(in_last),
    .m_flush(m_flush_s), .m_start(m_start_s), .m_char(m_char_s), .m_match(m_match_s),
    .hit(hit_s), .hit_pos(hit_pos_s), .hit_count(hit_count_s),
    .busy(busy_s), .done(done_s), .ovf(ovf_s)
  );

  // Matcher model for "01": token after a started "0", accept one cycle after the "1"
  always @(posedge clk) begin
    if (m_flush) begin
      tok     <= 1'b0;
      m_match <= 1'b0;
    end else begin
      tok     <= m_start && !m_char;
      m_match <= tok && m_char;
    end
  end

  // Same matcher model for the narrow instance
  always @(posedge clk) begin
    if (m_flush_s) begin
      tok_s     <= 1'b0;
      m_match_s <= 1'b0;
    end else begin
      tok_s     <= m_start_s && !m_char_s;
      m_match_s <= tok_s && m_char_s;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start_v, input logic anch_v, input logic valid_v,
                               input logic bit_v, input logic last_v);
    cmd_start    = start_v;
    cmd_anchored = anch_v;
    in_valid     = valid_v;
    in_bit       = bit_v;
    in_last      = last_v;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Issue cmd_start, check the flush cycle, land in SCAN
  task automatic startFrame(input string tag, input logic anch_v);
    applyStimulus(1'b1, anch_v, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    seen_hit = 1'b0;
    checkOutput($sformatf("%s_flush_m_flush", tag), m_flush, 1);
    checkOutput($sformatf("%s_flush_busy", tag), busy, 1);
    checkOutput($sformatf("%s_flush_in_ready", tag), in_ready, 0);
    checkOutput($sformatf("%s_flush_hit_count", tag), hit_count, 0);
    checkOutput($sformatf("%s_flush_ovf_s", tag), ovf_s, 0);
    tick();
  endtask

  // One transferred character; raw expectations are for the all-hits build
  task automatic scanStep(input string tag, input logic bit_v, input logic last_v,
                          input logic start_raw, input logic hit_raw, input int pos_v);
    logic gate;
    gate = !(STOP_MODE && seen_hit);
    applyStimulus(1'b0, 1'b0, 1'b1, bit_v, last_v);
    checkOutput($sformatf("%s_in_ready", tag), in_ready, 1);
    checkOutput($sformatf("%s_m_start", tag), m_start, start_raw & gate);
    checkOutput($sformatf("%s_m_char", tag), m_char, bit_v & gate);
    checkOutput($sformatf("%s_hit", tag), hit, hit_raw & gate);
    if (hit_raw && gate) begin
      checkOutput($sformatf("%s_hit_pos", tag), hit_pos, pos_v);
      seen_hit = 1'b1;
    end
    tick();
  endtask

  // The single drain cycle after the last character
  task automatic drainStep(input string tag, input logic hit_raw, input int pos_v);
    logic gate;
    gate = !(STOP_MODE && seen_hit);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput($sformatf("%s_drain_busy", tag), busy, 1);
    checkOutput($sformatf("%s_drain_done", tag), done, 0);
    checkOutput($sformatf("%s_drain_in_ready", tag), in_ready, 0);
    checkOutput($sformatf("%s_drain_hit", tag), hit, hit_raw & gate);
    if (hit_raw && gate) begin
      checkOutput($sformatf("%s_drain_hit_pos", tag), hit_pos, pos_v);
      seen_hit = 1'b1;
    end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    $display("[TB] reset values");
    checkOutput("rst_m_flush", m_flush, 1);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_m_start", m_start, 0);
    checkOutput("rst_m_char", m_char, 0);
    checkOutput("rst_hit", hit, 0);
    checkOutput("rst_hit_pos", hit_pos, 0);
    checkOutput("rst_hit_count", hit_count, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_hit_count_s", hit_count_s, 0);
    reset = 1'b0;
    tick();
    checkOutput("idle_m_flush", m_flush, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_done", done, 0);
    checkOutput("idle_in_ready", in_ready, 0);

    $display("[TB] non-anchored frame 0,1,0,1,1");
    startFrame("s1", 1'b0);
    scanStep("s1_c0", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    scanStep("s1_c1", 1'b1, 1'b0, 1'b1, 1'b0, 0);
    scanStep("s1_c2", 1'b0, 1'b0, 1'b1, 1'b1, 1);
    scanStep("s1_c3", 1'b1, 1'b0, 1'b1, 1'b0, 0);
    scanStep("s1_c4", 1'b1, 1'b1, 1'b1, 1'b1, 3);
    drainStep("s1", 1'b0, 0);
    checkOutput("s1_done", done, 1);
    checkOutput("s1_done_busy", busy, 0);
    checkOutput("s1_hit_count", hit_count, STOP_MODE ? 1 : 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("s1_done_m_start", m_start, 0);
    checkOutput("s1_done_m_char", m_char, 0);
    tick();
    checkOutput("s1_hold_hit_count", hit_count, STOP_MODE ? 1 : 2);
    checkOutput("s1_hold_done", done, 1);

    $display("[TB] anchored frame 0,1,0,1,1");
    startFrame("s2", 1'b1);
    scanStep("s2_c0", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    scanStep("s2_c1", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    scanStep("s2_c2", 1'b0, 1'b0, 1'b0, 1'b1, 1);
    scanStep("s2_c3", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    scanStep("s2_c4", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    drainStep("s2", 1'b0, 0);
    checkOutput("s2_done", done, 1);
    checkOutput("s2_hit_count", hit_count, 1);

    $display("[TB] reset mid-frame");
    startFrame("s3", 1'b0);
    scanStep("s3_c0", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    scanStep("s3_c1", 1'b1, 1'b0, 1'b1, 1'b0, 0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("s3_rst_m_flush", m_flush, 1);
    checkOutput("s3_rst_in_ready", in_ready, 0);
    checkOutput("s3_rst_m_start", m_start, 0);
    checkOutput("s3_rst_hit", hit, 0);
    checkOutput("s3_rst_hit_pos", hit_pos, 0);
    checkOutput("s3_rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s3_idle_m_flush", m_flush, 0);
    checkOutput("s3_idle_busy", busy, 0);
    checkOutput("s3_idle_done", done, 0);
    checkOutput("s3_idle_hit_count", hit_count, 0);
    startFrame("s3b", 1'b0);
    scanStep("s3b_c0", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    scanStep("s3b_c1", 1'b1, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("s3b_drain_count", hit_count, 0);
    drainStep("s3b", 1'b1, 1);
    checkOutput("s3b_hit_count", hit_count, 1);

    $display("[TB] valid gaps and cmd_start during SCAN");
    startFrame("s4", 1'b0);
    scanStep("s4_c0", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("s4_gap_m_start", m_start, 0);
    checkOutput("s4_gap_m_char", m_char, 0);
    checkOutput("s4_gap_in_ready", in_ready, 1);
    tick();
    scanStep("s4_c1", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    scanStep("s4_c2", 1'b1, 1'b1, 1'b1, 1'b0, 0);
    drainStep("s4", 1'b1, 2);
    checkOutput("s4_done", done, 1);
    checkOutput("s4_hit_count", hit_count, 1);

    $display("[TB] frame 0,1,0,1 for first-hit behaviour");
    startFrame("s5", 1'b0);
    scanStep("s5_c0", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    scanStep("s5_c1", 1'b1, 1'b0, 1'b1, 1'b0, 0);
    scanStep("s5_c2", 1'b0, 1'b0, 1'b1, 1'b1, 1);
    scanStep("s5_c3", 1'b1, 1'b1, 1'b1, 1'b0, 0);
    drainStep("s5", 1'b1, 3);
    checkOutput("s5_done", done, 1);
    checkOutput("s5_hit_count", hit_count, STOP_MODE ? 1 : 2);

    $display("[TB] ten-character frame, narrow instance saturates");
    startFrame("s6", 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, (i == 9), (i == 9));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s6_hit", hit, 1);
    checkOutput("s6_hit_pos", hit_pos, 9);
    checkOutput("s6_hit_s", hit_s, 1);
    checkOutput("s6_hit_pos_s", hit_pos_s, 7);
    tick();
    checkOutput("s6_done_s", done_s, 1);
    checkOutput("s6_ovf_s", ovf_s, 1);
    checkOutput("s6_ovf", ovf, 0);
    checkOutput("s6_hit_count_s", hit_count_s, 1);
    checkOutput("s6_hit_count", hit_count, 1);

    $display("[TB] new frame clears sticky overflow");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s7_m_flush_s", m_flush_s, 1);
    checkOutput("s7_ovf_s", ovf_s, 0);
    checkOutput("s7_hit_count_s", hit_count_s, 0);
    checkOutput("s7_busy_s", busy_s, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
